// File: rtl/alu_seq_nbit_if.sv
// Operand/result handshake bundle between the operand stage and the sequential ALU.
// Latency: none (wires only).
// Backpressure: In_ready/Out_ready carry stalls in each direction.
interface alu_seq_nbit_if #(
    parameter int WIDTH = 8
);
    logic             In_valid;
    logic             In_ready;
    logic [3:0]       Opcode;
    logic [WIDTH-1:0] Op1;
    logic [WIDTH-1:0] Op2;
    logic             Out_valid;
    logic             Out_ready;
    logic [WIDTH-1:0] Res;
    logic [WIDTH-1:0] ResHi;
    logic             C;
    logic             AC;
    logic             Z;
    logic             S;
    logic             V;

    // Producer of operations and consumer of results
    modport master (
        output In_valid, Opcode, Op1, Op2, Out_ready,
        input  In_ready, Out_valid, Res, ResHi, C, AC, Z, S, V
    );

    // The ALU itself
    modport slave (
        input  In_valid, Opcode, Op1, Op2, Out_ready,
        output In_ready, Out_valid, Res, ResHi, C, AC, Z, S, V
    );
endinterface

// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with carry-chained ops, shifts, flags and an iterative unsigned multiply.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL (one shift-add step per cycle).
// Backpressure: result held stable while Out_ready=0; In_ready=0 during MUL and while a result is stalled.
module alu_seq_nbit #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_nbit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int M  = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_COMP = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_NAND = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_ADC  = 4'h8;
    localparam logic [3:0] OP_SBB  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             c;
        logic             ac;
        logic             z;
        logic             s;
        logic             v;
    } result_t;

    state_t           state;
    result_t          res_q;
    result_t          alu_d;
    result_t          mul_d;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH:0]   cin_ext;
    logic             cin;
    logic             in_rdy;
    logic             accept;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mlo_q;
    logic [WIDTH:0]   mhi_q;
    logic [WIDTH:0]   mpart;
    logic [CW-1:0]    cnt_q;

    assign a      = bus.Op1;
    assign b      = bus.Op2;
    assign in_rdy = (state == S_IDLE) || ((state == S_DONE) && bus.Out_ready);
    assign accept = bus.In_valid && in_rdy;

    // Single-cycle result and flags; carry-in comes from the last registered C flag
    always_comb begin
        alu_d   = '0;
        cin     = ((bus.Opcode == OP_ADC) || (bus.Opcode == OP_SBB)) && res_q.c;
        cin_ext = {{WIDTH{1'b0}}, cin};
        sum     = {1'b0, a} + {1'b0, b} + cin_ext;
        dif     = {1'b0, a} - {1'b0, b} - cin_ext;
        case (bus.Opcode)
            OP_ADD, OP_ADC: begin
                alu_d.lo = sum[WIDTH-1:0];
                alu_d.c  = sum[WIDTH];
                // carry into bit 4 recovered from the sum bit
                alu_d.ac = a[4] ^ b[4] ^ sum[4];
                alu_d.v  = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB, OP_SBB: begin
                alu_d.lo = dif[WIDTH-1:0];
                alu_d.c  = dif[WIDTH];
                alu_d.ac = a[4] ^ b[4] ^ dif[4];
                alu_d.v  = (a[M] != b[M]) && (dif[M] != a[M]);
            end
            OP_COMP: alu_d.lo = ~a;
            OP_AND:  alu_d.lo = a & b;
            OP_OR:   alu_d.lo = a | b;
            OP_NAND: alu_d.lo = ~(a & b);
            OP_NOR:  alu_d.lo = ~(a | b);
            OP_XOR:  alu_d.lo = a ^ b;
            OP_SHL: begin
                alu_d.lo = {a[WIDTH-2:0], 1'b0};
                alu_d.c  = a[M];
            end
            OP_SHR: begin
                alu_d.lo = {1'b0, a[WIDTH-1:1]};
                alu_d.c  = a[0];
            end
            default: ;
        endcase
        // reserved codes keep every flag at 0, so Z/S only for defined single-cycle ops
        if (bus.Opcode <= OP_SHR) begin
            alu_d.z = (alu_d.lo == '0);
            alu_d.s = alu_d.lo[M];
        end
    end

    assign mpart = mlo_q[0] ? (mhi_q + {1'b0, mcand_q}) : mhi_q;

    // Final MUL result and flags from the shift-add registers
    always_comb begin
        mul_d    = '0;
        mul_d.hi = mhi_q[WIDTH-1:0];
        mul_d.lo = mlo_q;
        mul_d.c  = |mhi_q[WIDTH-1:0];
        mul_d.z  = ({mhi_q[WIDTH-1:0], mlo_q} == '0);
        mul_d.s  = mhi_q[M];
    end

    // Control FSM, multiplier iteration and result/flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            res_q   <= '0;
            mcand_q <= '0;
            mlo_q   <= '0;
            mhi_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                S_MUL: begin
                    if (cnt_q != '0) begin
                        {mhi_q, mlo_q} <= {1'b0, mpart, mlo_q[WIDTH-1:1]};
                        cnt_q          <= cnt_q - CW'(1);
                    end else begin
                        res_q <= mul_d;
                        state <= S_DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        if (bus.Opcode == OP_MUL) begin
                            mcand_q <= a;
                            mlo_q   <= b;
                            mhi_q   <= '0;
                            cnt_q   <= CW'(WIDTH);
                            state   <= S_MUL;
                        end else begin
                            res_q <= alu_d;
                            state <= S_DONE;
                        end
                    end else if ((state == S_DONE) && bus.Out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.In_ready  = in_rdy;
    assign bus.Out_valid = (state == S_DONE);
    assign bus.Res       = res_q.lo;
    assign bus.ResHi     = res_q.hi;
    assign bus.C         = res_q.c;
    assign bus.AC        = res_q.ac;
    assign bus.Z         = res_q.z;
    assign bus.S         = res_q.s;
    assign bus.V         = res_q.v;
endmodule

// File: tb/tb_alu_seq_nbit.sv
// Bench for alu_seq_nbit: directed literal cases plus randomized traffic against a queue model.
// Latency: model predicts the cycle each result becomes valid.
// Backpressure: Out_ready randomized; In_ready checked against the model every cycle.
module tb_alu_seq_nbit;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         c, ac, z, s, v;
        int           ready_at;
    } exp_t;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         c, ac, z, s, v, ov, ir;
    } snap_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t  q[$];
    snap_t sn;
    logic  mc;
    logic  checking;
    logic  just_reset;
    logic  exp_valid;
    logic  exp_ready;
    logic  acc_seen;

    alu_seq_nbit_if #(.WIDTH(W)) bus ();

    alu_seq_nbit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result of one operation computed from plain integer arithmetic
    function automatic exp_t model(input int op, input int a, input int b, input logic cin);
        exp_t e;
        int full, half, ci, r, sa, sb, sr, p;
        full = 1 << W;
        half = 1 << (W - 1);
        e.lo = '0; e.hi = '0;
        e.c = 0; e.ac = 0; e.z = 0; e.s = 0; e.v = 0;
        e.ready_at = 0;
        sa = (a >= half) ? a - full : a;
        sb = (b >= half) ? b - full : b;
        ci = (op == 8 || op == 9) ? int'(cin) : 0;
        case (op)
            0, 8: begin
                r = a + b + ci;
                e.lo = W'(r);
                e.c  = (r >= full);
                e.ac = ((a % 16) + (b % 16) + ci) >= 16;
                sr = sa + sb + ci;
                e.v  = (sr >= half) || (sr < -half);
            end
            1, 9: begin
                r = a - b - ci;
                e.lo = W'(r);
                e.c  = (r < 0);
                e.ac = ((a % 16) - (b % 16) - ci) < 0;
                sr = sa - sb - ci;
                e.v  = (sr >= half) || (sr < -half);
            end
            2:  e.lo = W'(full - 1 - a);
            3:  e.lo = W'(a & b);
            4:  e.lo = W'(a | b);
            5:  e.lo = W'(full - 1 - (a & b));
            6:  e.lo = W'(full - 1 - (a | b));
            7:  e.lo = W'(a ^ b);
            10: begin e.lo = W'(2 * a); e.c = (a >= half); end
            11: begin e.lo = W'(a / 2); e.c = ((a % 2) == 1); end
            12: begin
                p = a * b;
                e.lo = W'(p % full);
                e.hi = W'(p / full);
                e.c  = (p >= full);
                e.z  = (p == 0);
                e.s  = ((p / full) >= half);
            end
            default: ;
        endcase
        if (op <= 11) begin
            e.z = (e.lo == '0);
            e.s = e.lo[W-1];
        end
        return e;
    endfunction

    // One cycle: sample outputs after the falling edge, compare to model, advance model
    task automatic step();
        exp_t e;
        #1;
        sn.lo = bus.Res;  sn.hi = bus.ResHi;
        sn.c = bus.C; sn.ac = bus.AC; sn.z = bus.Z; sn.s = bus.S; sn.v = bus.V;
        sn.ov = bus.Out_valid; sn.ir = bus.In_ready;
        exp_valid = (q.size() > 0) && (cyc >= q[0].ready_at);
        exp_ready = (q.size() == 0) || (exp_valid && bus.Out_ready);
        if (checking) begin
            chk("out_valid", {31'd0, sn.ov}, {31'd0, exp_valid});
            chk("in_ready",  {31'd0, sn.ir}, {31'd0, exp_ready});
            if (exp_valid) begin
                chk("res",   {24'd0, sn.lo}, {24'd0, q[0].lo});
                chk("reshi", {24'd0, sn.hi}, {24'd0, q[0].hi});
                chk("flags", {27'd0, sn.c, sn.ac, sn.z, sn.s, sn.v},
                             {27'd0, q[0].c, q[0].ac, q[0].z, q[0].s, q[0].v});
            end
            if (just_reset) begin
                chk("rst_res",   {24'd0, sn.lo}, 32'd0);
                chk("rst_reshi", {24'd0, sn.hi}, 32'd0);
                chk("rst_flags", {27'd0, sn.c, sn.ac, sn.z, sn.s, sn.v}, 32'd0);
            end
        end
        just_reset = 1'b0;
        if (rst) begin
            q.delete();
            mc = 1'b0;
            just_reset = 1'b1;
        end else begin
            if (exp_valid && bus.Out_ready) void'(q.pop_front());
            if (bus.In_valid && sn.ir) begin
                e = model(int'(bus.Opcode), int'(bus.Op1), int'(bus.Op2), mc);
                mc = e.c;
                e.ready_at = cyc + 1 + ((bus.Opcode == 4'hC) ? W + 1 : 0);
                q.push_back(e);
                acc_seen = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Issue one op with Out_ready=1 and wait for its result
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output snap_t got, output int edges, output int lowcnt);
        int n;
        int acc_cyc;
        bus.In_valid = 1'b1; bus.Opcode = op; bus.Op1 = a; bus.Op2 = b;
        bus.Out_ready = 1'b1;
        acc_seen = 1'b0;
        n = 0;
        while (!acc_seen && n < 50) begin step(); n++; end
        if (!acc_seen) chk("accept_timeout", 32'd0, 32'd1);
        acc_cyc = cyc;
        bus.In_valid = 1'b0;
        lowcnt = 0;
        n = 0;
        do begin
            step();
            if (!sn.ir) lowcnt++;
            n++;
        end while (!sn.ov && n < 50);
        if (!sn.ov) chk("result_timeout", 32'd0, 32'd1);
        got = sn;
        edges = cyc - 1 - acc_cyc;
    endtask

    initial begin
        snap_t got;
        int edges, lowcnt, n;
        logic [W-1:0] vals[4];
        int cys[4];

        checking = 1'b0; just_reset = 1'b0; mc = 1'b0; acc_seen = 1'b0;
        rst = 1'b1;
        bus.In_valid = 1'b0; bus.Opcode = 4'h0; bus.Op1 = '0; bus.Op2 = '0;
        bus.Out_ready = 1'b0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        checking = 1'b1;
        step();
        chk("reset_out_valid", {31'd0, sn.ov}, 32'd0);
        chk("reset_in_ready",  {31'd0, sn.ir}, 32'd1);

        do_op(4'h0, 8'h0F, 8'h01, got, edges, lowcnt);
        chk("add0f01_res", {24'd0, got.lo}, 32'h10);
        chk("add0f01_flags", {27'd0, got.c, got.ac, got.z, got.s, got.v}, 32'b01000);

        do_op(4'h0, 8'h7F, 8'h01, got, edges, lowcnt);
        chk("add7f01_res", {24'd0, got.lo}, 32'h80);
        chk("add7f01_csv", {29'd0, got.c, got.s, got.v}, 32'b011);

        do_op(4'h1, 8'h00, 8'h01, got, edges, lowcnt);
        chk("sub0001_res", {24'd0, got.lo}, 32'hFF);
        chk("sub0001_c_ac_s", {29'd0, got.c, got.ac, got.s}, 32'b111);

        do_op(4'h9, 8'h05, 8'h02, got, edges, lowcnt);
        chk("sbb0502_res", {24'd0, got.lo}, 32'h02);
        chk("sbb0502_c", {31'd0, got.c}, 32'd0);

        do_op(4'hC, 8'hFF, 8'hFF, got, edges, lowcnt);
        chk("mulffff_prod", {16'd0, got.hi, got.lo}, 32'hFE01);
        chk("mulffff_c", {31'd0, got.c}, 32'd1);
        chk("mulffff_latency", edges, 32'd9);
        chk("mulffff_inready_low", lowcnt, 32'd9);

        // back-pressure: XOR result held for several stalled cycles
        bus.Out_ready = 1'b0;
        bus.In_valid = 1'b1; bus.Opcode = 4'h7; bus.Op1 = 8'hAA; bus.Op2 = 8'hAA;
        acc_seen = 1'b0;
        step();
        chk("xor_accept", {31'd0, acc_seen}, 32'd1);
        bus.In_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bp_hold", {28'd0, sn.ov, sn.ir, sn.z, |sn.lo}, 32'b1010);
        end
        bus.Out_ready = 1'b1;
        bus.In_valid = 1'b1; bus.Opcode = 4'h3; bus.Op1 = 8'hF0; bus.Op2 = 8'h3C;
        acc_seen = 1'b0;
        step();
        chk("bp_and_accept", {31'd0, acc_seen}, 32'd1);
        bus.In_valid = 1'b0;
        step();
        chk("bp_and_res", {23'd0, sn.ov, sn.lo}, {23'd0, 1'b1, 8'h30});

        // back-to-back ADDs
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                bus.In_valid = 1'b1; bus.Opcode = 4'h0;
                bus.Op1 = W'((i + 1) * 16); bus.Op2 = W'(i + 1);
            end else begin
                bus.In_valid = 1'b0;
            end
            step();
            if (sn.ov && n < 4) begin vals[n] = sn.lo; cys[n] = cyc; n++; end
        end
        chk("b2b_count", n, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                chk("b2b_res", {24'd0, vals[i]}, 32'(8'h11 * (i + 1)));
                if (i > 0) chk("b2b_spacing", cys[i] - cys[i-1], 32'd1);
            end
        end

        // reset in the middle of a multiply
        bus.In_valid = 1'b1; bus.Opcode = 4'hC; bus.Op1 = 8'h12; bus.Op2 = 8'h34;
        acc_seen = 1'b0;
        step();
        bus.In_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("midmul_rst_valid_ready", {30'd0, sn.ov, sn.ir}, 32'b01);
        chk("midmul_rst_res", {16'd0, sn.hi, sn.lo}, 32'd0);
        do_op(4'h8, 8'h01, 8'h01, got, edges, lowcnt);
        chk("adc_after_rst", {24'd0, got.lo}, 32'h02);

        // randomized traffic, including stalls, reserved codes and occasional reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.In_valid = !rst && ($urandom_range(0, 9) < 7);
            bus.Opcode = 4'($urandom_range(0, 15));
            bus.Op1 = W'($urandom);
            bus.Op2 = W'($urandom);
            bus.Out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        rst = 1'b0;
        bus.In_valid = 1'b0;
        bus.Out_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
